// File: rtl/led_shift_driver.sv
// Serial driver for chained 595-class LED shift/latch ICs: valid/ready frame in,
// sdata/sclk out at a divided rate, then a latch pulse. Optional PWM dimming via LED_DRV_PWM_EN.
module led_shift_driver #(
  parameter int DATA_W    = 16,
  parameter int CLK_DIV   = 4,
  parameter int LATCH_CYC = 2,
  parameter int MSB_FIRST = 1,
  parameter int BYTE_SWAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              sclk,
  output logic              sdata,
  output logic              latch,
  output logic              busy,
  output logic              oe_n
`ifdef LED_DRV_PWM_EN
  ,
  input  logic [7:0]        bright
`endif
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam int LAT_W = $clog2(LATCH_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [DATA_W-1:0]  r_shift;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit_cnt;
  logic [LAT_W-1:0]   r_lat_cnt;
  logic               r_sclk;
  logic               r_sdata;
  logic               r_latch;
  logic               r_busy;
  logic               r_in_ready;
  logic               r_oe_n;

  logic [DATA_W-1:0]  w_cap;
  logic [DATA_W-1:0]  w_shift_nxt;
  logic               w_first_bit;
  logic               w_next_bit;
  logic               w_accept;
  logic               w_div_wrap;
  logic               w_rise;
  logic               w_fall;
  logic               w_last_fall;
  logic               w_lat_done;

  // Byte order is reversed at capture so the shifter itself never cares about it.
  if (BYTE_SWAP != 0 && (DATA_W % 8) == 0) begin : g_swap
    for (genvar b = 0; b < DATA_W / 8; b++) begin : g_byte
      assign w_cap[8*b +: 8] = in_data[DATA_W-8-8*b +: 8];
    end
  end else begin : g_noswap
    assign w_cap = in_data;
  end

  assign w_shift_nxt = (MSB_FIRST != 0) ? (r_shift << 1) : (r_shift >> 1);
  assign w_first_bit = (MSB_FIRST != 0) ? w_cap[DATA_W-1] : w_cap[0];
  assign w_next_bit  = (MSB_FIRST != 0) ? w_shift_nxt[DATA_W-1] : w_shift_nxt[0];

  assign w_accept    = (r_state == S_IDLE) && r_in_ready && in_valid;
  assign w_div_wrap  = (r_state == S_SHIFT) && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise      = w_div_wrap && !r_sclk;
  assign w_fall      = w_div_wrap && r_sclk;
  assign w_last_fall = w_fall && (r_bit_cnt == BIT_W'(DATA_W));
  assign w_lat_done  = (r_state == S_LATCH) && (r_lat_cnt == LAT_W'(LATCH_CYC));

  // NOTE: every path assigns the default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept)    w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last_fall) w_state_nxt = S_LATCH;
      S_LATCH: if (w_lat_done)  w_state_nxt = S_IDLE;
      default:                  w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_div      <= '0;
      r_bit_cnt  <= '0;
      r_lat_cnt  <= '0;
      r_sclk     <= 1'b0;
      r_sdata    <= 1'b0;
      r_latch    <= 1'b0;
      r_busy     <= 1'b0;
      r_in_ready <= 1'b0;
    end else begin
      r_in_ready <= (w_state_nxt == S_IDLE);
      r_busy     <= (w_state_nxt != S_IDLE);
      r_latch    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_shift   <= w_cap;
            r_sdata   <= w_first_bit;
            r_div     <= '0;
            r_bit_cnt <= '0;
            r_lat_cnt <= '0;
            r_sclk    <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (w_div_wrap) begin
            r_div  <= '0;
            r_sclk <= !r_sclk;
          end else begin
            r_div  <= r_div + DIV_W'(1);
          end
          if (w_rise) r_bit_cnt <= r_bit_cnt + BIT_W'(1);
          // The last falling edge leaves sdata on the final bit through LATCH.
          if (w_fall && !w_last_fall) begin
            r_shift <= w_shift_nxt;
            r_sdata <= w_next_bit;
          end
        end
        S_LATCH: begin
          // First LATCH cycle keeps latch low as setup after the final sclk fall.
          if (!w_lat_done) begin
            r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            r_latch   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LED_DRV_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_bright_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt  <= 8'd0;
      r_bright_q <= 8'd0;
      r_oe_n     <= 1'b1;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (w_lat_done) r_bright_q <= bright;
      r_oe_n    <= !(r_pwm_cnt < r_bright_q);
    end
  end
`else
  // Outputs stay disabled until the chain holds a fully latched frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_oe_n <= 1'b1;
    else if (w_lat_done) r_oe_n <= 1'b0;
  end
`endif

  assign in_ready = r_in_ready;
  assign sclk     = r_sclk;
  assign sdata    = r_sdata;
  assign latch    = r_latch;
  assign busy     = r_busy;
  assign oe_n     = r_oe_n;

endmodule

// File: tb/tb_led_shift_driver.sv
// Directed bench for led_shift_driver: default instance (A) plus an
// 8-bit, LSB-first, no-swap, CLK_DIV=1 instance (B).
module tb_led_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_data;
  logic        a_valid, a_ready, a_sclk, a_sdata, a_latch, a_busy, a_oe_n;
  logic [7:0]  b_data;
  logic        b_valid, b_ready, b_sclk, b_sdata, b_latch, b_busy, b_oe_n;
`ifdef LED_DRV_PWM_EN
  logic [7:0]  bright;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  led_shift_driver u_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .sclk(a_sclk), .sdata(a_sdata), .latch(a_latch),
    .busy(a_busy), .oe_n(a_oe_n)
`ifdef LED_DRV_PWM_EN
    , .bright(bright)
`endif
  );

  led_shift_driver #(
    .DATA_W(8), .CLK_DIV(1), .LATCH_CYC(2), .MSB_FIRST(0), .BYTE_SWAP(0)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .sclk(b_sclk), .sdata(b_sdata), .latch(b_latch),
    .busy(b_busy), .oe_n(b_oe_n)
`ifdef LED_DRV_PWM_EN
    , .bright(bright)
`endif
  );

  // Chain-side receivers: first bit shifted in ends up in the MSB.
  logic [15:0] a_rx = '0;
  logic [7:0]  b_rx = '0;
  int a_rises = 0, a_latches = 0, b_rises = 0, b_latches = 0;
  always @(posedge a_sclk)  begin a_rx = {a_rx[14:0], a_sdata}; a_rises++; end
  always @(posedge a_latch) a_latches++;
  always @(posedge b_sclk)  begin b_rx = {b_rx[6:0], b_sdata}; b_rises++; end
  always @(posedge b_latch) b_latches++;

  task automatic start_a(input logic [15:0] d);
    @(negedge clk); a_data = d; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0; a_data = ~d;
  endtask

  task automatic start_b(input logic [7:0] d);
    @(negedge clk); b_data = d; b_valid = 1'b1;
    @(posedge clk); #1; b_valid = 1'b0; b_data = ~d;
  endtask

  // Samples #1 after each edge until in_ready; len is edges counted from the accept edge.
  task automatic wait_done(input bit sel, output int len, output int fr, output int sr,
                           output int lh, output int bad_lat);
    logic prev, s;
    len = -1; fr = -1; sr = -1; lh = 0; bad_lat = 0; prev = 1'b0;
    for (int i = 1; i <= 2000; i++) begin
      @(posedge clk); #1;
      s = sel ? b_sclk : a_sclk;
      if (s && !prev) begin
        if (fr < 0) fr = i;
        else if (sr < 0) sr = i;
      end
      prev = s;
      if (sel ? b_latch : a_latch) begin lh++; if (s) bad_lat++; end
      if (sel ? b_ready : a_ready) begin len = i; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0;
    repeat (3) @(posedge clk); #1;
    if (a_sclk !== 1'b0)  begin $display("FAIL reset_sclk: got %b want 0", a_sclk); n_bad++; end n_cmp++;
    if (a_sdata !== 1'b0) begin $display("FAIL reset_sdata: got %b want 0", a_sdata); n_bad++; end n_cmp++;
    if (a_latch !== 1'b0) begin $display("FAIL reset_latch: got %b want 0", a_latch); n_bad++; end n_cmp++;
    if (a_busy !== 1'b0)  begin $display("FAIL reset_busy: got %b want 0", a_busy); n_bad++; end n_cmp++;
    if (a_ready !== 1'b0) begin $display("FAIL reset_ready: got %b want 0", a_ready); n_bad++; end n_cmp++;
    if (a_oe_n !== 1'b1)  begin $display("FAIL reset_oe_n: got %b want 1", a_oe_n); n_bad++; end n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    if (a_ready !== 1'b1) begin $display("FAIL reset_ready_rise_a: got %b want 1", a_ready); n_bad++; end n_cmp++;
    if (b_ready !== 1'b1) begin $display("FAIL reset_ready_rise_b: got %b want 1", b_ready); n_bad++; end n_cmp++;
  endtask

  task automatic test_msb_swap;
    int r0, l0, len, fr, sr, lh, bl;
    r0 = a_rises; l0 = a_latches;
    start_a(16'hA5C3);
    if (a_busy !== 1'b1)  begin $display("FAIL msb_busy: got %b want 1", a_busy); n_bad++; end n_cmp++;
    if (a_ready !== 1'b0) begin $display("FAIL msb_ready_low: got %b want 0", a_ready); n_bad++; end n_cmp++;
    if (a_sclk !== 1'b0)  begin $display("FAIL msb_sclk0: got %b want 0", a_sclk); n_bad++; end n_cmp++;
    if (a_sdata !== 1'b1) begin $display("FAIL msb_first_bit: got %b want 1", a_sdata); n_bad++; end n_cmp++;
    wait_done(1'b0, len, fr, sr, lh, bl);
    if (len !== 131) begin $display("FAIL msb_frame_len: got %0d want 131", len); n_bad++; end n_cmp++;
    if (fr !== 4)    begin $display("FAIL msb_first_rise: got %0d want 4", fr); n_bad++; end n_cmp++;
    if (sr - fr !== 8) begin $display("FAIL msb_sclk_period: got %0d want 8", sr - fr); n_bad++; end n_cmp++;
    if (lh !== 2)    begin $display("FAIL msb_latch_width: got %0d want 2", lh); n_bad++; end n_cmp++;
    if (bl !== 0)    begin $display("FAIL msb_sclk_in_latch: got %0d want 0", bl); n_bad++; end n_cmp++;
    if (a_rises - r0 !== 16) begin $display("FAIL msb_bit_count: got %0d want 16", a_rises - r0); n_bad++; end n_cmp++;
    if (a_rx !== 16'hC3A5) begin $display("FAIL msb_rx_bits: got %h want c3a5", a_rx); n_bad++; end n_cmp++;
    if (a_latches - l0 !== 1) begin $display("FAIL msb_latch_pulses: got %0d want 1", a_latches - l0); n_bad++; end n_cmp++;
    if (a_busy !== 1'b0) begin $display("FAIL msb_busy_end: got %b want 0", a_busy); n_bad++; end n_cmp++;
`ifndef LED_DRV_PWM_EN
    if (a_oe_n !== 1'b0) begin $display("FAIL msb_oe_n_enabled: got %b want 0", a_oe_n); n_bad++; end n_cmp++;
`endif
  endtask

  task automatic test_lsb_small;
    int r0, l0, len, fr, sr, lh, bl;
    r0 = b_rises; l0 = b_latches;
    start_b(8'h01);
    if (b_sdata !== 1'b1) begin $display("FAIL lsb_first_bit: got %b want 1", b_sdata); n_bad++; end n_cmp++;
    wait_done(1'b1, len, fr, sr, lh, bl);
    if (len !== 19)  begin $display("FAIL lsb_frame_len: got %0d want 19", len); n_bad++; end n_cmp++;
    if (fr !== 1)    begin $display("FAIL lsb_first_rise: got %0d want 1", fr); n_bad++; end n_cmp++;
    if (sr - fr !== 2) begin $display("FAIL lsb_sclk_period: got %0d want 2", sr - fr); n_bad++; end n_cmp++;
    if (lh !== 2)    begin $display("FAIL lsb_latch_width: got %0d want 2", lh); n_bad++; end n_cmp++;
    if (b_rises - r0 !== 8) begin $display("FAIL lsb_bit_count: got %0d want 8", b_rises - r0); n_bad++; end n_cmp++;
    if (b_rx !== 8'h80) begin $display("FAIL lsb_rx_bits: got %h want 80", b_rx); n_bad++; end n_cmp++;
    if (b_latches - l0 !== 1) begin $display("FAIL lsb_latch_pulses: got %0d want 1", b_latches - l0); n_bad++; end n_cmp++;
  endtask

  task automatic test_back_to_back;
    int r0, l0, len, fr, sr, lh, bl;
    r0 = a_rises; l0 = a_latches;
    start_a(16'h0000);
    repeat (40) @(posedge clk);
    @(negedge clk); a_data = 16'hFFFF; a_valid = 1'b1;
    wait_done(1'b0, len, fr, sr, lh, bl);
    if (len < 0) begin $display("FAIL b2b_ready_timeout: got %0d want >0", len); n_bad++; end n_cmp++;
    if (a_rx !== 16'h0000) begin $display("FAIL b2b_first_rx: got %h want 0000", a_rx); n_bad++; end n_cmp++;
    if (a_rises - r0 !== 16) begin $display("FAIL b2b_first_bits: got %0d want 16", a_rises - r0); n_bad++; end n_cmp++;
    if (a_latches - l0 !== 1) begin $display("FAIL b2b_first_latch: got %0d want 1", a_latches - l0); n_bad++; end n_cmp++;
    @(posedge clk); #1; a_valid = 1'b0;
    if (a_busy !== 1'b1) begin $display("FAIL b2b_second_accept: got %b want 1", a_busy); n_bad++; end n_cmp++;
    wait_done(1'b0, len, fr, sr, lh, bl);
    if (len !== 131) begin $display("FAIL b2b_second_len: got %0d want 131", len); n_bad++; end n_cmp++;
    if (a_rx !== 16'hFFFF) begin $display("FAIL b2b_second_rx: got %h want ffff", a_rx); n_bad++; end n_cmp++;
    if (a_latches - l0 !== 2) begin $display("FAIL b2b_total_latch: got %0d want 2", a_latches - l0); n_bad++; end n_cmp++;
  endtask

  task automatic test_reset_mid;
    int r0, l0, len, fr, sr, lh, bl;
    bit hit;
    r0 = a_rises; l0 = a_latches; hit = 1'b0;
    start_a(16'hA5C3);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (a_rises - r0 == 7) begin hit = 1'b1; break; end
    end
    if (hit !== 1'b1) begin $display("FAIL rstmid_reach_bit7: got %b want 1", hit); n_bad++; end n_cmp++;
    rst_n = 1'b0; #1;
    if (a_sclk !== 1'b0)  begin $display("FAIL rstmid_sclk: got %b want 0", a_sclk); n_bad++; end n_cmp++;
    if (a_sdata !== 1'b0) begin $display("FAIL rstmid_sdata: got %b want 0", a_sdata); n_bad++; end n_cmp++;
    if (a_latch !== 1'b0) begin $display("FAIL rstmid_latch: got %b want 0", a_latch); n_bad++; end n_cmp++;
    if (a_busy !== 1'b0)  begin $display("FAIL rstmid_busy: got %b want 0", a_busy); n_bad++; end n_cmp++;
    if (a_oe_n !== 1'b1)  begin $display("FAIL rstmid_oe_n: got %b want 1", a_oe_n); n_bad++; end n_cmp++;
    repeat (3) @(posedge clk);
    if (a_latches - l0 !== 0) begin $display("FAIL rstmid_no_latch: got %0d want 0", a_latches - l0); n_bad++; end n_cmp++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    r0 = a_rises;
    start_a(16'h3C96);
    wait_done(1'b0, len, fr, sr, lh, bl);
    if (len !== 131) begin $display("FAIL rstmid_next_len: got %0d want 131", len); n_bad++; end n_cmp++;
    if (a_rises - r0 !== 16) begin $display("FAIL rstmid_next_bits: got %0d want 16", a_rises - r0); n_bad++; end n_cmp++;
    if (a_rx !== 16'h963C) begin $display("FAIL rstmid_next_rx: got %h want 963c", a_rx); n_bad++; end n_cmp++;
    if (a_latches - l0 !== 1) begin $display("FAIL rstmid_next_latch: got %0d want 1", a_latches - l0); n_bad++; end n_cmp++;
  endtask

`ifdef LED_DRV_PWM_EN
  task automatic test_pwm;
    int len, fr, sr, lh, bl, lows;
    bright = 8'd64;
    start_a(16'h1234);
    wait_done(1'b0, len, fr, sr, lh, bl);
    lows = 0;
    for (int i = 0; i < 256; i++) begin @(posedge clk); #1; if (a_oe_n == 1'b0) lows++; end
    if (lows !== 64) begin $display("FAIL pwm_64_lows: got %0d want 64", lows); n_bad++; end n_cmp++;
    start_a(16'h4321);
    repeat (20) @(posedge clk);
    @(negedge clk); bright = 8'd0;
    wait_done(1'b0, len, fr, sr, lh, bl);
    lows = 0;
    for (int i = 0; i < 256; i++) begin @(posedge clk); #1; if (a_oe_n == 1'b0) lows++; end
    if (lows !== 0) begin $display("FAIL pwm_0_lows: got %0d want 0", lows); n_bad++; end n_cmp++;
  endtask
`endif

  initial begin
`ifdef LED_DRV_PWM_EN
    bright = 8'd0;
`endif
    test_reset();
    test_msb_swap();
    test_lsb_small();
    test_back_to_back();
    test_reset_mid();
`ifdef LED_DRV_PWM_EN
    test_pwm();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
